sub_16bit_serial: RTL and testbench

Multi-cycle 16-bit two's-complement subtractor computing A - B as A + ~B + 1. It processes one 4-bit slice per clock, LSB slice first, and carries the borrow/carry chain in a register between slices. It is the subtract-side counterpart of the ALU's combinational 16-bit ripple adder. It sits in the ALU beside that adder and serves SUB and compare-style operations that can tolerate 4-cycle latency. It generates Z/V/N flags for the flag register, with optional saturation.

---
 rtl/sub_16bit_serial.sv | 103 ++++++++++
 tb/tb_sub_16bit_serial.sv | 190 +++++++++++++++++++
 2 files changed

// File: rtl/sub_16bit_serial.sv
// sub_16bit_serial: 4-cycle nibble-serial A-B (A + ~B + 1) with Z/V/N/borrow flags and optional saturation
module sub_16bit_serial #(
  parameter bit SAT_EN = 1'b1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [15:0] A,
  input  logic [15:0] B,
  output logic        busy,
  output logic        done,
  output logic [15:0] Diff,
  output logic        Bout,
  output logic        Z,
  output logic        V,
  output logic        N
);
  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;
  state_t state_q, state_d;
  logic [15:0] a_q, a_d, nb_q, nb_d, raw_q, raw_d, diff_q, diff_d;
  logic [1:0] k_q, k_d;
  logic carry_q, carry_d, bout_q, bout_d, z_q, z_d, v_q, v_d, n_q, n_d;
  logic [4:0] sum;
  logic [15:0] raw_fin, sat_diff;
  logic v_fin;
  assign sum = {1'b0, a_q[{k_q, 2'b00} +: 4]} + {1'b0, nb_q[{k_q, 2'b00} +: 4]} + {4'd0, carry_q};
  always_comb begin
    raw_fin = raw_q;
    raw_fin[{k_q, 2'b00} +: 4] = sum[3:0];
  end
  // nb_q holds ~B, so equal sign bits here mean A and B had opposite signs
  assign v_fin = (a_q[15] == nb_q[15]) && (raw_fin[15] != a_q[15]);
  assign sat_diff = (SAT_EN && v_fin) ? (a_q[15] ? 16'h8000 : 16'h7FFF) : raw_fin;
  always_comb begin
    state_d = state_q;
    a_d = a_q;
    nb_d = nb_q;
    raw_d = raw_q;
    carry_d = carry_q;
    k_d = k_q;
    diff_d = diff_q;
    bout_d = bout_q;
    z_d = z_q;
    v_d = v_q;
    n_d = n_q;
    if (start && state_q != BUSY) begin
      state_d = BUSY;
      a_d = A;
      nb_d = ~B;
      carry_d = 1'b1;
      raw_d = 16'h0000;
      k_d = 2'd0;
    end else if (state_q == DONE) begin
      state_d = IDLE;
    end else if (state_q == BUSY) begin
      raw_d = raw_fin;
      carry_d = sum[4];
      k_d = k_q + 2'd1;
      if (k_q == 2'd3) begin
        state_d = DONE;
        diff_d = sat_diff;
        bout_d = ~sum[4];
        v_d = v_fin;
        z_d = sat_diff == 16'h0000;
        n_d = sat_diff[15];
      end
    end
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      a_q <= '0;
      nb_q <= '0;
      raw_q <= '0;
      carry_q <= 1'b0;
      k_q <= '0;
      diff_q <= '0;
      bout_q <= 1'b0;
      z_q <= 1'b0;
      v_q <= 1'b0;
      n_q <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q <= a_d;
      nb_q <= nb_d;
      raw_q <= raw_d;
      carry_q <= carry_d;
      k_q <= k_d;
      diff_q <= diff_d;
      bout_q <= bout_d;
      z_q <= z_d;
      v_q <= v_d;
      n_q <= n_d;
    end
  end
  assign busy = state_q == BUSY;
  assign done = state_q == DONE;
  assign Diff = diff_q;
  assign Bout = bout_q;
  assign Z = z_q;
  assign V = v_q;
  assign N = n_q;
endmodule

// File: tb/tb_sub_16bit_serial.sv
// tb_sub_16bit_serial: directed checks of the serial subtractor, saturating and wrapping instances side by side
module tb_sub_16bit_serial;
  logic clk = 1'b0, rst_n = 1'b0, start = 1'b0;
  logic [15:0] A = '0, B = '0;
  logic busy, done, Bout, Z, V, N;
  logic [15:0] Diff;
  logic busy_w, done_w, bout_w, z_w, v_w, n_w;
  logic [15:0] diff_w;
  int n_chk = 0, n_fail = 0;

  sub_16bit_serial #(.SAT_EN(1'b1)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .A(A), .B(B),
    .busy(busy), .done(done), .Diff(Diff), .Bout(Bout), .Z(Z), .V(V), .N(N)
  );
  sub_16bit_serial #(.SAT_EN(1'b0)) dut_w (
    .clk(clk), .rst_n(rst_n), .start(start), .A(A), .B(B),
    .busy(busy_w), .done(done_w), .Diff(diff_w), .Bout(bout_w), .Z(z_w), .V(v_w), .N(n_w)
  );

  always #5 clk = ~clk;

  task automatic start_op(input logic [15:0] a, input logic [15:0] b);
    @(negedge clk);
    A = a;
    B = b;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_done(output int cyc, output int bc);
    cyc = 0;
    bc = 0;
    while (!done && cyc < 20) begin
      if (busy) bc++;
      @(negedge clk);
      cyc++;
    end
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    n_chk++;
    if ({busy, done, Diff, Bout, Z, V, N} !== 22'd0) begin
      n_fail++;
      $display("FAIL reset_outputs: got busy=%b done=%b Diff=%h flags=%b expected all zero", busy, done, Diff, {Bout, Z, V, N});
    end
    rst_n = 1'b1;
  endtask

  task automatic test_basic;
    int cyc, bc;
    start_op(16'h0005, 16'h0003);
    wait_done(cyc, bc);
    n_chk++;
    if (cyc !== 4) begin n_fail++; $display("FAIL basic_latency: got %0d expected 4", cyc); end
    n_chk++;
    if (bc !== 4) begin n_fail++; $display("FAIL basic_busy_cycles: got %0d expected 4", bc); end
    n_chk++;
    if (Diff !== 16'h0002) begin n_fail++; $display("FAIL basic_diff: got %h expected 0002", Diff); end
    n_chk++;
    if ({Bout, Z, V, N} !== 4'b0000) begin n_fail++; $display("FAIL basic_flags: got %b expected 0000", {Bout, Z, V, N}); end
    @(negedge clk);
    n_chk++;
    if (done !== 1'b0 || Diff !== 16'h0002) begin n_fail++; $display("FAIL basic_done_pulse: got done=%b Diff=%h expected 0 0002", done, Diff); end
  endtask

  task automatic test_borrow;
    int cyc, bc;
    start_op(16'h0003, 16'h0005);
    wait_done(cyc, bc);
    n_chk++;
    if (Diff !== 16'hFFFE) begin n_fail++; $display("FAIL borrow_diff: got %h expected fffe", Diff); end
    n_chk++;
    if ({Bout, Z, V, N} !== 4'b1001) begin n_fail++; $display("FAIL borrow_flags: got %b expected 1001", {Bout, Z, V, N}); end
    @(negedge clk);
  endtask

  task automatic test_neg_ovf;
    int cyc, bc;
    start_op(16'h8000, 16'h0001);
    wait_done(cyc, bc);
    n_chk++;
    if (Diff !== 16'h8000) begin n_fail++; $display("FAIL negovf_sat_diff: got %h expected 8000", Diff); end
    n_chk++;
    if ({Bout, Z, V, N} !== 4'b0011) begin n_fail++; $display("FAIL negovf_sat_flags: got %b expected 0011", {Bout, Z, V, N}); end
    n_chk++;
    if (diff_w !== 16'h7FFF) begin n_fail++; $display("FAIL negovf_wrap_diff: got %h expected 7fff", diff_w); end
    n_chk++;
    if ({bout_w, z_w, v_w, n_w} !== 4'b0010) begin n_fail++; $display("FAIL negovf_wrap_flags: got %b expected 0010", {bout_w, z_w, v_w, n_w}); end
    @(negedge clk);
  endtask

  task automatic test_pos_ovf;
    int cyc, bc;
    start_op(16'h7FFF, 16'hFFFF);
    wait_done(cyc, bc);
    n_chk++;
    if (Diff !== 16'h7FFF) begin n_fail++; $display("FAIL posovf_sat_diff: got %h expected 7fff", Diff); end
    n_chk++;
    if ({Bout, Z, V, N} !== 4'b1010) begin n_fail++; $display("FAIL posovf_sat_flags: got %b expected 1010", {Bout, Z, V, N}); end
    n_chk++;
    if (diff_w !== 16'h8000 || n_w !== 1'b1) begin n_fail++; $display("FAIL posovf_wrap: got Diff=%h N=%b expected 8000 1", diff_w, n_w); end
    @(negedge clk);
  endtask

  task automatic test_equal_ignore_start;
    int cyc, bc;
    start_op(16'h1234, 16'h1234);
    @(negedge clk);
    A = 16'hFFFF;
    B = 16'h0001;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_done(cyc, bc);
    n_chk++;
    if (cyc !== 2) begin n_fail++; $display("FAIL equal_latency: got %0d remaining cycles expected 2", cyc); end
    n_chk++;
    if (Diff !== 16'h0000) begin n_fail++; $display("FAIL equal_diff: got %h expected 0000", Diff); end
    n_chk++;
    if ({Bout, Z, V, N} !== 4'b0100) begin n_fail++; $display("FAIL equal_flags: got %b expected 0100", {Bout, Z, V, N}); end
    @(negedge clk);
  endtask

  task automatic test_back_to_back;
    int cyc, bc, gap;
    @(negedge clk);
    A = 16'h0010;
    B = 16'h0001;
    start = 1'b1;
    wait_done(cyc, bc);
    n_chk++;
    if (Diff !== 16'h000F || cyc !== 5) begin n_fail++; $display("FAIL b2b_first: got Diff=%h cyc=%0d expected 000f 5", Diff, cyc); end
    A = 16'h0001;
    B = 16'h0010;
    @(negedge clk);
    start = 1'b0;
    gap = 1;
    while (!done && gap < 20) begin
      @(negedge clk);
      gap++;
    end
    n_chk++;
    if (gap !== 5) begin n_fail++; $display("FAIL b2b_gap: got %0d expected 5", gap); end
    n_chk++;
    if (Diff !== 16'hFFF1 || {Bout, Z, V, N} !== 4'b1001) begin n_fail++; $display("FAIL b2b_second: got Diff=%h flags=%b expected fff1 1001", Diff, {Bout, Z, V, N}); end
    @(negedge clk);
  endtask

  task automatic test_reset_mid;
    int cyc, bc, seen;
    start_op(16'h0005, 16'h0003);
    repeat (2) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    n_chk++;
    if (busy !== 1'b0 || Diff !== 16'h0000) begin n_fail++; $display("FAIL resetmid_clear: got busy=%b Diff=%h expected 0 0000", busy, Diff); end
    seen = 0;
    repeat (8) begin
      if (done) seen++;
      @(negedge clk);
    end
    n_chk++;
    if (seen !== 0) begin n_fail++; $display("FAIL resetmid_no_done: got %0d done cycles expected 0", seen); end
    start_op(16'h0100, 16'h0001);
    wait_done(cyc, bc);
    n_chk++;
    if (cyc !== 4 || Diff !== 16'h00FF || {Bout, Z, V, N} !== 4'b0000) begin
      n_fail++;
      $display("FAIL resetmid_after: got cyc=%0d Diff=%h flags=%b expected 4 00ff 0000", cyc, Diff, {Bout, Z, V, N});
    end
    @(negedge clk);
  endtask

  initial begin
    test_reset;
    test_basic;
    test_borrow;
    test_neg_ovf;
    test_pos_ovf;
    test_equal_ignore_start;
    test_back_to_back;
    test_reset_mid;
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
